// File: rtl/fb_update_ctrl.sv
// Framebuffer refresh sequencer: filters image select, waits for vblank, optional clear pass (FB_CLEAR_EN), starts copier.
// Latency: vblank sample to copy_start is 1 cycle, FB_WORDS+1 cycles with FB_CLEAR_EN.
// Backpressure: none; waits on the copy_done level and aborts after TIMEOUT_CYC cycles.
module fb_update_ctrl #(
    parameter int         FB_WORDS    = 76800,
    parameter int         ADDR_W      = 19,
    parameter int         SEL_W       = 2,
    parameter int         STABLE_CYC  = 16,
    parameter int         TIMEOUT_CYC = 1 << 20,
    parameter logic [7:0] CLEAR_COLOR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              vblank,
    input  logic              copy_done,
    output logic              copy_start,
    output logic [SEL_W-1:0]  copy_sel,
    output logic [ADDR_W-1:0] clr_wraddr,
    output logic [7:0]        clr_data,
    output logic              clr_wren,
    output logic              wr_mux_clr,
    output logic              display_hold,
    output logic              busy,
    output logic              timeout_err
);

    localparam int SCW = $clog2(STABLE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_VB   = 3'd1,
        CLEAR     = 3'd2,
        START     = 3'd3,
        WAIT_LOW  = 3'd4,
        WAIT_DONE = 3'd5,
        FIN       = 3'd6
    } state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] sel_meta, sel_sync, stab_val, next_sel;
    logic [SCW-1:0]   stab_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic             pending, pwr_load;
    logic             accept, capture, finish, tmo_hit, tmo_last, clr_last;

    assign accept   = (sel_sync == stab_val) && (stab_cnt == SCW'(STABLE_CYC - 1));
    assign tmo_last = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    // Switch synchronizer and stability filter; stab_cnt saturates so accept fires once per hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_meta <= '0;
            sel_sync <= '0;
            stab_val <= '0;
            stab_cnt <= SCW'(STABLE_CYC);
        end else begin
            sel_meta <= sel_in;
            sel_sync <= sel_meta;
            if (sel_sync != stab_val) begin
                stab_val <= sel_sync;
                stab_cnt <= SCW'(1);
            end else if (stab_cnt != SCW'(STABLE_CYC)) begin
                stab_cnt <= stab_cnt + SCW'(1);
            end
        end
    end

    // An accepted value is compared with whatever the display will show after this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 1'b1;
            pwr_load <= 1'b1;
            next_sel <= '0;
            copy_sel <= '0;
        end else begin
            if (capture) begin
                copy_sel <= next_sel;
                pwr_load <= 1'b0;
            end
            if (accept) begin
                next_sel <= stab_val;
                pending  <= (stab_val != (capture ? next_sel : copy_sel)) || (pwr_load && !capture);
            end else begin
                if (pwr_load)
                    next_sel <= sel_sync;
                if (capture)
                    pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        finish    = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE:      if (pending) state_nxt = WAIT_VB;
            WAIT_VB: begin
                if (vblank) begin
                    capture = 1'b1;
`ifdef FB_CLEAR_EN
                    state_nxt = CLEAR;
`else
                    state_nxt = START;
`endif
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR:     if (clr_last) state_nxt = START;
`endif
            START:     state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (tmo_last) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end else if (!copy_done) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (copy_done) begin
                    finish    = 1'b1;
                    state_nxt = FIN;
                end else if (tmo_last) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FIN:       state_nxt = pending ? WAIT_VB : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt      <= '0;
            busy         <= 1'b1;
            display_hold <= 1'b1;
            timeout_err  <= 1'b0;
        end else begin
            if (state == WAIT_LOW || state == WAIT_DONE)
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
            if (finish || tmo_hit)
                busy <= 1'b0;
            else if (state_nxt == WAIT_VB)
                busy <= 1'b1;
            if (capture)
                display_hold <= 1'b1;
            else if (finish || tmo_hit)
                display_hold <= 1'b0;
            if (tmo_hit)
                timeout_err <= 1'b1;
        end
    end

    assign copy_start = (state == START);
    assign clr_data   = CLEAR_COLOR;

`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_addr;

    assign clr_last = (clr_addr == ADDR_W'(FB_WORDS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            clr_addr <= '0;
        else if (state == CLEAR)
            clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
    end

    assign clr_wraddr = clr_addr;
    assign clr_wren   = (state == CLEAR);
    assign wr_mux_clr = (state == CLEAR);
`else
    assign clr_last   = 1'b0;
    assign clr_wraddr = '0;
    assign clr_wren   = 1'b0;
    assign wr_mux_clr = 1'b0;
`endif

endmodule
